inst_buffer: RTL and testbench
==============================

INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 Parameter DEPTH, default 4096, number of 128-bit instruction lines; power of two, at most 4096.
REQ-002 i_clk  input  1  sole clock; all logic on its rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_host_wr_start  input  1  begin new program load; clears write pointer, beat counter and instruction count.
REQ-005 i_host_wr_en  input  1  host 32-bit beat valid.
REQ-006 i_host_wr_data  input  32  host beat data.
REQ-007 o_host_ready  output  1  beat is accepted when high.
REQ-008 i_npu_idle  input  1  scheduler idle indication; loading is permitted only while high.
REQ-009 i_pc  input  12  read address from the scheduler.
REQ-010 i_rd_en  input  1  read request from the scheduler.
REQ-011 o_inst  output  128  instruction to the decoder.
REQ-012 o_inst_valid  output  1  one-cycle pulse qualifying o_inst.
REQ-013 o_inst_count  output  13  number of complete lines loaded, 0..DEPTH.
REQ-014 o_rd_oob  output  1  pulse with o_inst_valid when the read address was at or above o_inst_count.

Function
REQ-015 o_host_ready SHALL equal i_npu_idle AND (o_inst_count < DEPTH).
REQ-016 A beat with i_host_wr_en and o_host_ready SHALL be accepted; all other beats are dropped silently.
REQ-017 Beats SHALL pack little-endian: beat k fills bits [32k+31:32k], k = 0..3, with a 2-bit beat counter.
REQ-018 On acceptance of beat 3, the line SHALL be written at address o_inst_count, the count SHALL increment by 1 in the next cycle, and the beat counter SHALL wrap to 0.
REQ-019 i_host_wr_start SHALL zero the count and beat counter and discard partial beats; if i_host_wr_en is also high in the same cycle and o_host_ready is high, that beat SHALL be taken as beat 0 of the new program.
REQ-020 i_rd_en in cycle N SHALL produce o_inst_valid=1 in cycle N+1, with o_inst holding the line at i_pc (sampled in cycle N); latency is fixed at 1.
REQ-021 If i_pc >= o_inst_count (sampled in cycle N), o_inst SHALL be all zeros (NOP) and o_rd_oob=1 in cycle N+1.
REQ-022 A read and a line write to the same address in the same cycle SHALL return the old contents (read-first).
REQ-023 o_inst SHALL hold its last value while no read is in progress; o_inst_valid and o_rd_oob SHALL be low unless a read completes.
REQ-024 If i_npu_idle deasserts mid-line, partial beats SHALL be retained, and loading resumes when i_npu_idle returns high.

Reset
REQ-025 On i_rst: o_inst=0, o_inst_valid=0, o_rd_oob=0, count=0, beat counter=0, partial line=0; array contents are not reset.
REQ-026 Reset asserted mid-read SHALL suppress the pending o_inst_valid.

Configuration
REQ-027 With INST_BUF_PARITY_EN defined:
- an extra bit per line SHALL store even parity over the 128 bits;
- output o_parity_err (1 bit) SHALL pulse with o_inst_valid on a mismatch, and reset to 0;
- an out-of-range read SHALL never flag o_parity_err.
REQ-028 Without INST_BUF_PARITY_EN, neither the parity storage nor the o_parity_err port SHALL exist.

Structure
REQ-029 Shared package npu_inst_pkg SHALL hold INST_W=128, HOST_W=32, PC_W=12 and NOP_INST=0.
REQ-030 Beat assembly SHALL reside in a sub-module inst_word_packer (beat counter plus 96-bit holding register, emitting a line-valid strobe); storage and read logic stay in inst_buffer.

Verification
REQ-031 Load 8 beats 0x0..0x7 with i_npu_idle=1 -> line0=0x00000003_00000002_00000001_00000000, line1 likewise from 4..7, o_inst_count=2.
REQ-032 i_rd_en with i_pc=1 in cycle N -> o_inst_valid=1 and line1 in N+1; i_pc=5 -> o_inst=0 and o_rd_oob=1.
REQ-033 Two beats, then i_host_wr_start with a beat 0xAA -> count=0, and after 3 more beats line0[31:0]=0xAA.
REQ-034 Drop i_npu_idle after beat 2 and toggle i_host_wr_en for 5 cycles -> no beats accepted; after idle returns, one more beat completes line0.
REQ-035 Fill DEPTH=4 with 16 beats -> o_host_ready=0, a 17th beat is ignored, o_inst_count=4.
REQ-036 With INST_BUF_PARITY_EN defined, force-flip one stored bit, then read that line -> o_parity_err=1 together with o_inst_valid.

Source files
------------

// File: rtl/npu_inst_pkg.sv
// Shared widths and helpers for the NPU instruction path.
// Parity storage in inst_buffer is enabled by defining INST_BUF_PARITY_EN.
package npu_inst_pkg;

    localparam int unsigned INST_W = 128;
    localparam int unsigned HOST_W = 32;
    localparam int unsigned PC_W   = 12;
    localparam int unsigned CNT_W  = PC_W + 1;
    localparam int unsigned HOLD_W = INST_W - HOST_W;

    localparam logic [INST_W-1:0] NOP_INST = '0;

    // Position of the next host beat inside the 128-bit line.
    typedef enum logic [1:0] {
        Beat0 = 2'd0,
        Beat1 = 2'd1,
        Beat2 = 2'd2,
        Beat3 = 2'd3
    } beat_idx_e;

    // Even-parity bit: makes the total number of ones (line plus bit) even.
    function automatic logic even_parity(input logic [INST_W-1:0] line);
        return ^line;
    endfunction

endpackage

// File: rtl/inst_word_packer.sv
// Assembles four little-endian 32-bit host beats into one 128-bit line.
// Emits a single-cycle strobe together with the completed line on the fourth beat.
module inst_word_packer
    import npu_inst_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_beat_en,
    input  logic [HOST_W-1:0] i_beat_data,
    output logic [INST_W-1:0] o_line,
    output logic              o_line_valid
);

    beat_idx_e         beat_q;
    logic [HOLD_W-1:0] hold_q;

    // The last beat bypasses the holding register straight into the line.
    assign o_line       = {i_beat_data, hold_q};
    assign o_line_valid = i_beat_en && !i_start && (beat_q == Beat3);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            beat_q <= Beat0;
            hold_q <= '0;
        end else if (i_start) begin
            // A beat arriving with start becomes beat 0 of the new program.
            if (i_beat_en) begin
                beat_q <= Beat1;
                hold_q <= {{(HOLD_W - HOST_W){1'b0}}, i_beat_data};
            end else begin
                beat_q <= Beat0;
                hold_q <= '0;
            end
        end else if (i_beat_en) begin
            unique case (beat_q)
                Beat0: begin
                    hold_q[HOST_W-1:0] <= i_beat_data;
                    beat_q             <= Beat1;
                end
                Beat1: begin
                    hold_q[2*HOST_W-1:HOST_W] <= i_beat_data;
                    beat_q                    <= Beat2;
                end
                Beat2: begin
                    hold_q[3*HOST_W-1:2*HOST_W] <= i_beat_data;
                    beat_q                      <= Beat3;
                end
                Beat3: begin
                    hold_q <= '0;
                    beat_q <= Beat0;
                end
                default: begin
                    hold_q <= '0;
                    beat_q <= Beat0;
                end
            endcase
        end
    end

endmodule

// File: rtl/inst_buffer.sv
// Instruction line store loaded by the host in 32-bit beats and read by the scheduler.
// Define INST_BUF_PARITY_EN to add per-line even parity and the o_parity_err output.
module inst_buffer
    import npu_inst_pkg::*;
#(
    parameter int unsigned DEPTH = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_host_wr_start,
    input  logic              i_host_wr_en,
    input  logic [HOST_W-1:0] i_host_wr_data,
    output logic              o_host_ready,
    input  logic              i_npu_idle,
    input  logic [PC_W-1:0]   i_pc,
    input  logic              i_rd_en,
    output logic [INST_W-1:0] o_inst,
    output logic              o_inst_valid,
    output logic [CNT_W-1:0]  o_inst_count,
    output logic              o_rd_oob
`ifdef INST_BUF_PARITY_EN
    ,
    output logic              o_parity_err
`endif
);

    localparam int unsigned      AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [INST_W-1:0] mem [DEPTH];
`ifdef INST_BUF_PARITY_EN
    logic              par_mem [DEPTH];
`endif

    logic [CNT_W-1:0]  count_q;
    logic              beat_acc;
    logic              line_valid;
    logic [INST_W-1:0] line_data;
    logic              rd_oob;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;

    assign o_host_ready = i_npu_idle && (count_q < DEPTH_C);
    assign beat_acc     = i_host_wr_en && o_host_ready;
    assign o_inst_count = count_q;
    assign wr_addr      = count_q[AW-1:0];
    assign rd_addr      = i_pc[AW-1:0];
    // In-range addresses are below count, which never exceeds DEPTH, so rd_addr cannot alias.
    assign rd_oob       = {1'b0, i_pc} >= count_q;

    inst_word_packer u_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_host_wr_start),
        .i_beat_en    (beat_acc),
        .i_beat_data  (i_host_wr_data),
        .o_line       (line_data),
        .o_line_valid (line_valid)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
        end else if (i_host_wr_start) begin
            count_q <= '0;
        end else if (line_valid) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Array is not reset; nonblocking write gives read-first behaviour on collisions.
    always_ff @(posedge i_clk) begin
        if (line_valid) begin
            mem[wr_addr] <= line_data;
`ifdef INST_BUF_PARITY_EN
            par_mem[wr_addr] <= even_parity(line_data);
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_inst       <= NOP_INST;
            o_inst_valid <= 1'b0;
            o_rd_oob     <= 1'b0;
        end else begin
            o_inst_valid <= i_rd_en;
            o_rd_oob     <= i_rd_en && rd_oob;
            if (i_rd_en) begin
                o_inst <= rd_oob ? NOP_INST : mem[rd_addr];
            end
        end
    end

`ifdef INST_BUF_PARITY_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_parity_err <= 1'b0;
        end else begin
            o_parity_err <= i_rd_en && !rd_oob &&
                            (even_parity(mem[rd_addr]) != par_mem[rd_addr]);
        end
    end
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer (DEPTH=4) with a read scoreboard and a behavioural load model.
module tb_inst_buffer;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_host_wr_start;
    logic         i_host_wr_en;
    logic [31:0]  i_host_wr_data;
    logic         o_host_ready;
    logic         i_npu_idle;
    logic [11:0]  i_pc;
    logic         i_rd_en;
    logic [127:0] o_inst;
    logic         o_inst_valid;
    logic [12:0]  o_inst_count;
    logic         o_rd_oob;
`ifdef INST_BUF_PARITY_EN
    logic         o_parity_err;
`endif

    inst_buffer #(.DEPTH(4)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_host_wr_start (i_host_wr_start),
        .i_host_wr_en    (i_host_wr_en),
        .i_host_wr_data  (i_host_wr_data),
        .o_host_ready    (o_host_ready),
        .i_npu_idle      (i_npu_idle),
        .i_pc            (i_pc),
        .i_rd_en         (i_rd_en),
        .o_inst          (o_inst),
        .o_inst_valid    (o_inst_valid),
        .o_inst_count    (o_inst_count),
        .o_rd_oob        (o_rd_oob)
`ifdef INST_BUF_PARITY_EN
        ,
        .o_parity_err    (o_parity_err)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [127:0] inst;
        logic         oob;
        logic         perr;
    } rd_exp_t;

    rd_exp_t      sb[$];
    int           n_vec  = 0;
    int           n_miss = 0;

    // Reference model of the load path
    logic [127:0] m_mem [4];
    logic         m_bad [4];
    int           m_count;
    int           m_beat;
    logic [127:0] m_part;
    logic [127:0] last_inst;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count   = 0;
        m_beat    = 0;
        m_part    = '0;
        last_inst = '0;
        for (int i = 0; i < 4; i++) m_bad[i] = 1'b0;
    endtask

    // One clock: drive inputs, check ready, update model, then check outputs after the edge.
    task automatic cycle(input logic st, input logic we, input logic [31:0] d,
                         input logic re, input logic [11:0] pc);
        rd_exp_t e;
        logic    rdy;
        i_host_wr_start = st;
        i_host_wr_en    = we;
        i_host_wr_data  = d;
        i_rd_en         = re;
        i_pc            = pc;
        #1;
        rdy = i_npu_idle && (m_count < 4);
        chk("host_ready", 128'(o_host_ready), 128'(rdy));
        if (re) begin
            e.oob  = (int'(pc) >= m_count);
            e.inst = e.oob ? '0 : m_mem[pc[1:0]];
            e.perr = !e.oob && m_bad[pc[1:0]];
            sb.push_back(e);
        end
        if (st) begin
            m_count = 0;
            m_beat  = 0;
            m_part  = '0;
        end
        if (we && rdy) begin
            m_part[m_beat*32 +: 32] = d;
            if (m_beat == 3) begin
                m_mem[m_count] = m_part;
                m_bad[m_count] = 1'b0;
                m_count++;
                m_beat = 0;
                m_part = '0;
            end else begin
                m_beat++;
            end
        end
        @(posedge i_clk);
        #1;
        if (re) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 128'(1), 128'(0));
            end else begin
                e = sb.pop_front();
                chk("inst_valid", 128'(o_inst_valid), 128'(1));
                chk("inst", o_inst, e.inst);
                chk("rd_oob", 128'(o_rd_oob), 128'(e.oob));
`ifdef INST_BUF_PARITY_EN
                chk("parity_err", 128'(o_parity_err), 128'(e.perr));
`endif
                last_inst = e.inst;
            end
        end else begin
            chk("idle_valid", 128'(o_inst_valid), 128'(0));
            chk("idle_oob", 128'(o_rd_oob), 128'(0));
            chk("inst_hold", o_inst, last_inst);
        end
        chk("inst_count", 128'(o_inst_count), 128'(m_count));
    endtask

    task automatic beat(input logic [31:0] d);
        cycle(1'b0, 1'b1, d, 1'b0, 12'd0);
    endtask

    task automatic rd(input logic [11:0] pc);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, pc);
    endtask

    task automatic nop();
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 12'd0);
    endtask

    initial begin
        i_rst           = 1'b1;
        i_host_wr_start = 1'b0;
        i_host_wr_en    = 1'b0;
        i_host_wr_data  = '0;
        i_npu_idle      = 1'b1;
        i_pc            = '0;
        i_rd_en         = 1'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_inst", o_inst, '0);
        chk("rst_valid", 128'(o_inst_valid), 128'(0));
        chk("rst_oob", 128'(o_rd_oob), 128'(0));
        chk("rst_count", 128'(o_inst_count), 128'(0));
        i_rst = 1'b0;
        nop();

        // Two lines from beats 0..7
        for (int k = 0; k < 8; k++) beat(32'(k));
        nop();
        chk("line0_literal", m_mem[0], 128'h00000003_00000002_00000001_00000000);
        rd(12'd1);
        chk("line1_literal", o_inst, 128'h00000007_00000006_00000005_00000004);
        rd(12'd0);
        rd(12'd5);
        rd(12'd2);
        nop();
        nop();

`ifdef INST_BUF_PARITY_EN
        dut.mem[1][7] = ~dut.mem[1][7];
        m_mem[1][7]   = ~m_mem[1][7];
        m_bad[1]      = 1'b1;
        rd(12'd1);
        rd(12'd5);
        rd(12'd0);
`endif

        // Restart mid-line with a beat taken as beat 0
        beat(32'h10);
        beat(32'h11);
        cycle(1'b1, 1'b1, 32'hAA, 1'b0, 12'd0);
        chk("restart_count", 128'(o_inst_count), 128'(0));
        beat(32'hB1);
        beat(32'hB2);
        beat(32'hB3);
        rd(12'd0);
        chk("restart_beat0", 128'(o_inst[31:0]), 128'(32'hAA));

        // Idle drop mid-line keeps partial beats
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 12'd0);
        beat(32'hC0);
        beat(32'hC1);
        beat(32'hC2);
        i_npu_idle = 1'b0;
        for (int k = 0; k < 5; k++) cycle(1'b0, k[0] == 1'b0, 32'hDEAD0000 + 32'(k), 1'b0, 12'd0);
        i_npu_idle = 1'b1;
        beat(32'hC3);
        rd(12'd0);
        chk("idle_resume_line", o_inst, 128'h000000C3_000000C2_000000C1_000000C0);

        // Fill to DEPTH, extra beat dropped, collision read on an unwritten address
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 12'd0);
        for (int k = 0; k < 15; k++) beat(32'hF0 + 32'(k));
        cycle(1'b0, 1'b1, 32'hFF, 1'b1, 12'd3);
        beat(32'h1234_5678);
        chk("full_count", 128'(o_inst_count), 128'(4));
        chk("full_ready", 128'(o_host_ready), 128'(0));
        rd(12'd3);
        rd(12'd0);
        rd(12'd4);
        rd(12'd4095);
        nop();

        // Reset during a pending read suppresses the response
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 12'd0);
        i_rd_en = 1'b1;
        i_pc    = 12'd0;
        #2;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        chk("rst_mid_valid", 128'(o_inst_valid), 128'(0));
        chk("rst_mid_inst", o_inst, '0);
        i_rd_en = 1'b0;
        i_rst   = 1'b0;
        model_reset();
        nop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        n_miss++;
        $display("FAIL timeout observed=running expected=finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "bench timeout");
    end

endmodule
